id_ex_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 28 ++
 rtl/id_ex_stage_main_decoder.sv | 51 +++++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions
// for the MIPS pipeline stages.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_main_decoder.sv
// Main control decoder: opcode to control bundle
// plus whether the instruction reads rt.
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rt
);

  always_comb begin
    ctrl    = CTRL_NOP;
    uses_rt = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_FUNCT;
        uses_rt       = 1'b1;
      end
      (opcode == OP_LW): begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      (opcode == OP_SW): begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        uses_rt       = 1'b1;
      end
      (opcode == OP_BEQ): begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALUOP_SUB;
        uses_rt     = 1'b1;
      end
      (opcode == OP_ADDI): begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      default: begin
        ctrl    = CTRL_NOP;
        uses_rt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: decode, load-use hazard detection
// and the ID/EX pipeline register.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic [1:0]        ex_aluop,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_pc4
);

  ctrl_t             dec_ctrl;
  logic              uses_rt;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              hz, load;

  ctrl_t             ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [5:0]        funct_q, funct_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  main_decoder u_dec (
    .opcode  (id_instr[31:26]),
    .ctrl    (dec_ctrl),
    .uses_rt (uses_rt)
  );

  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign id_rd = id_instr[15:11];

  // A load in EX whose target feeds ID cannot be forwarded in time.
  assign hz = valid_q & ctrl_q.memread
            & (rt_q != '0) & id_valid
            & ((rt_q == id_rs)
              | ((rt_q == id_rt) & uses_rt));

  assign stall = hz & ~flush;
  assign load  = id_valid & ~flush & ~hz;

  always_comb begin
    ctrl_d  = CTRL_NOP;
    valid_d = 1'b0;
    funct_d = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    pc4_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    if (load) begin
      ctrl_d  = dec_ctrl;
      valid_d = 1'b1;
      funct_d = id_instr[5:0];
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = {{(DATA_W-16){id_instr[15]}},
                 id_instr[15:0]};
      pc4_d   = id_pc4;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      funct_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      funct_q <= funct_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_regdst   = ctrl_q.regdst;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_funct    = funct_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_pc4      = pc4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, load-use
// stalls, flush priority and asynchronous reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic        ex_regwrite, ex_memtoreg, ex_memread;
  logic        ex_memwrite, ex_branch, ex_alusrc;
  logic        ex_regdst;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_rd1      (id_rd1),
    .id_rd2      (id_rd2),
    .flush       (flush),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_memtoreg (ex_memtoreg),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_branch   (ex_branch),
    .ex_alusrc   (ex_alusrc),
    .ex_regdst   (ex_regdst),
    .ex_aluop    (ex_aluop),
    .ex_funct    (ex_funct),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_pc4      (ex_pc4)
  );

  // {regwrite,memtoreg,memread,memwrite,branch,alusrc,regdst,aluop}
  function automatic logic [8:0] ctl();
    return {ex_regwrite, ex_memtoreg, ex_memread,
            ex_memwrite, ex_branch, ex_alusrc,
            ex_regdst, ex_aluop};
  endfunction

  function automatic logic [31:0] data_or();
    return ex_rd1 | ex_rd2 | ex_imm | ex_pc4
         | {26'd0, ex_funct}
         | {17'd0, ex_rs, ex_rt, ex_rd};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins);
    id_valid = 1'b1;
    id_instr = ins;
  endtask

  initial begin
    reset    = 1'b1;
    id_valid = 1'b0;
    id_instr = '0;
    id_pc4   = '0;
    id_rd1   = '0;
    id_rd2   = '0;
    flush    = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ctl", {23'd0, ctl()}, 32'd0);
    chk("rst_data", data_or(), 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // R-type add $8,$9,$10
    reset  = 1'b0;
    present(32'h012A4020);
    id_rd1 = 32'd5;
    id_rd2 = 32'd7;
    id_pc4 = 32'h104;
    tick();
    chk("rt_valid", {31'd0, ex_valid}, 32'd1);
    chk("rt_ctl", {23'd0, ctl()}, {23'd0, 9'b1000001_10});
    chk("rt_funct", {26'd0, ex_funct}, 32'h20);
    chk("rt_regs", {17'd0, ex_rs, ex_rt, ex_rd},
        {17'd0, 5'd9, 5'd10, 5'd8});
    chk("rt_rd1", ex_rd1, 32'd5);
    chk("rt_rd2", ex_rd2, 32'd7);
    chk("rt_pc4", ex_pc4, 32'h104);
    chk("rt_imm", ex_imm, 32'h00004020);

    // asynchronous reset mid-cycle
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_ctl", {23'd0, ctl()}, 32'd0);
    chk("arst_data", data_or(), 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("arst_hold", {31'd0, ex_valid}, 32'd0);
    reset = 1'b0;
    #2;
    chk("arst_rel", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("arst_after", {31'd0, ex_valid}, 32'd1);

    // load-use: lw $8,4($9) then add $9,$8,$9
    present(32'h8D280004);
    #1;
    chk("lu_nostall0", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_lw_ctl", {23'd0, ctl()}, {23'd0, 9'b1110010_00});
    chk("lu_lw_rt", {27'd0, ex_rt}, 32'd8);
    chk("lu_lw_imm", ex_imm, 32'd4);
    present(32'h01094820);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_ctl", {23'd0, ctl()}, 32'd0);
    chk("lu_bub_data", data_or(), 32'd0);
    chk("lu_bub_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_regs", {17'd0, ex_rs, ex_rt, ex_rd},
        {17'd0, 5'd8, 5'd9, 5'd9});
    chk("lu_add_ctl", {23'd0, ctl()}, {23'd0, 9'b1000001_10});

    // lw to $0 never stalls
    present(32'h8D200004);
    tick();
    present(32'h00004820);
    #1;
    chk("zero_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("zero_valid", {31'd0, ex_valid}, 32'd1);

    // addi whose destination matches the load target
    present(32'h8D280004);
    tick();
    present(32'h21280005);
    #1;
    chk("addi_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("addi_ctl", {23'd0, ctl()}, {23'd0, 9'b1000010_00});

    // flush beats hazard
    present(32'h8D280004);
    tick();
    present(32'h01094820);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_data", data_or(), 32'd0);

    // addi with negative immediate
    present(32'h2128FFFC);
    tick();
    chk("neg_imm", ex_imm, 32'hFFFFFFFC);
    chk("neg_ctl", {23'd0, ctl()}, {23'd0, 9'b1000010_00});

    // sw
    present(32'hAD280008);
    tick();
    chk("sw_ctl", {23'd0, ctl()}, {23'd0, 9'b0001010_00});

    // beq
    present(32'h11280003);
    tick();
    chk("beq_ctl", {23'd0, ctl()}, {23'd0, 9'b0000100_01});

    // unknown opcode 0x3F
    present(32'hFD281234);
    tick();
    chk("unk_valid", {31'd0, ex_valid}, 32'd1);
    chk("unk_ctl", {23'd0, ctl()}, 32'd0);
    chk("unk_rs", {27'd0, ex_rs}, 32'd9);

    // empty slot
    id_valid = 1'b0;
    tick();
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_data", data_or(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
